usb_host_xact: RTL and testbench

Host-side USB transaction sequencer: the initiator counterpart to the device-side control/bulk transfer logic. It accepts one transaction command (SETUP/OUT/IN to an address/endpoint) and drives the token port of `encode_packet`. For OUT/SETUP it then sends a DATAx packet; for IN it returns the decoded DATAx payload. It waits for or sends the handshake, enforces a response timeout, and reports a single result code. It sits between a host scheduler and the existing `encode_packet`/`decode_packet` pair.

---
 rtl/usb_host_xact_if.sv | 42 ++++
 rtl/usb_host_xact.sv | 96 +++++++++
 tb/tb_usb_host_xact.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_host_xact_if.sv
// usb_host_xact_if: command, packet-engine and payload stream signals of the host transaction sequencer
interface usb_host_xact_if;
  logic       cmd_valid_i, cmd_ready_o, cmd_tog_i;
  logic [1:0] cmd_type_i;
  logic [6:0] cmd_addr_i;
  logic [3:0] cmd_endp_i;
  logic       done_o;
  logic [2:0] result_o;
  logic       tok_send_o, tok_done_i;
  logic [1:0] tok_type_o;
  logic [15:0] tok_data_o;
  logic       trn_tsend_o, trn_busy_i, trn_tdone_i;
  logic [1:0] trn_ttype_o;
  logic       hsk_send_o, hsk_sent_i, hsk_recv_i;
  logic [1:0] hsk_type_o, hsk_type_i;
  logic       out_recv_i, crc_err_i;
  logic [1:0] out_type_i;
  logic       s_tvalid_i, s_tready_o, s_tlast_i;
  logic [7:0] s_tdata_i;
  logic       trn_tvalid_o, trn_tready_i, trn_tlast_o;
  logic [7:0] trn_tdata_o;
  logic       rx_tvalid_i, rx_tready_o, rx_tlast_i;
  logic [7:0] rx_tdata_i;
  logic       m_tvalid_o, m_tready_i, m_tlast_o;
  logic [7:0] m_tdata_o;
  modport slave (
    input  cmd_valid_i, cmd_type_i, cmd_addr_i, cmd_endp_i, cmd_tog_i, tok_done_i, trn_busy_i,
           trn_tdone_i, hsk_sent_i, hsk_recv_i, hsk_type_i, out_recv_i, out_type_i, crc_err_i,
           s_tvalid_i, s_tlast_i, s_tdata_i, trn_tready_i, rx_tvalid_i, rx_tlast_i, rx_tdata_i, m_tready_i,
    output cmd_ready_o, done_o, result_o, tok_send_o, tok_type_o, tok_data_o, trn_tsend_o, trn_ttype_o,
           hsk_send_o, hsk_type_o, s_tready_o, trn_tvalid_o, trn_tlast_o, trn_tdata_o,
           rx_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o
  );
  modport master (
    output cmd_valid_i, cmd_type_i, cmd_addr_i, cmd_endp_i, cmd_tog_i, tok_done_i, trn_busy_i,
           trn_tdone_i, hsk_sent_i, hsk_recv_i, hsk_type_i, out_recv_i, out_type_i, crc_err_i,
           s_tvalid_i, s_tlast_i, s_tdata_i, trn_tready_i, rx_tvalid_i, rx_tlast_i, rx_tdata_i, m_tready_i,
    input  cmd_ready_o, done_o, result_o, tok_send_o, tok_type_o, tok_data_o, trn_tsend_o, trn_ttype_o,
           hsk_send_o, hsk_type_o, s_tready_o, trn_tvalid_o, trn_tlast_o, trn_tdata_o,
           rx_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o
  );
endinterface

// File: rtl/usb_host_xact.sv
// usb_host_xact: host-side USB transaction sequencer driving token, data and handshake packets
module usb_host_xact #(
  parameter int TIMEOUT = 128
) (
  input logic clock,
  input logic reset,
  usb_host_xact_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, TOKEN, DATA_TX, WAIT_HSK, WAIT_DATA, RECV, CRC_CHK, SEND_ACK, DONE} state_t;
  state_t state, next;
  logic [1:0] typ;
  logic [6:0] addr;
  logic [3:0] endp;
  logic tog, mism, crc_seen, cnt, tok_send, tsend, hsend, acc, waiting, tmo, is_in, crc_any;
  logic [2:0] res, res_n, hsk_res;
  logic [TW-1:0] timer;
  assign acc = state == IDLE && bus.cmd_valid_i;
  assign waiting = state == WAIT_HSK || state == WAIT_DATA;
  assign tmo = timer == TW'(TIMEOUT - 1);
  assign is_in = typ == 2'b10;
  assign crc_any = bus.crc_err_i || crc_seen;
  assign hsk_res = bus.hsk_type_i == 2'b01 ? 3'd3 : bus.hsk_type_i == 2'b10 ? 3'd1 :
                   bus.hsk_type_i == 2'b11 ? 3'd2 : 3'd0;
  assign bus.cmd_ready_o = state == IDLE;
  assign bus.done_o = state == DONE;
  assign bus.result_o = res;
  assign bus.tok_send_o = tok_send;
  assign bus.tok_type_o = typ;
  assign bus.tok_data_o = {5'b0, endp, addr};
  assign bus.trn_tsend_o = tsend;
  assign bus.trn_ttype_o = {tog, 1'b0};
  assign bus.hsk_send_o = hsend;
  assign bus.hsk_type_o = 2'b00;
  assign bus.trn_tvalid_o = state == DATA_TX && bus.s_tvalid_i;
  assign bus.trn_tlast_o = state == DATA_TX && bus.s_tlast_i;
  assign bus.trn_tdata_o = state == DATA_TX ? bus.s_tdata_i : 8'h00;
  assign bus.s_tready_o = state == DATA_TX && bus.trn_tready_i;
  assign bus.m_tvalid_o = state == RECV && bus.rx_tvalid_i;
  assign bus.m_tlast_o = state == RECV && bus.rx_tlast_i;
  assign bus.m_tdata_o = state == RECV ? bus.rx_tdata_i : 8'h00;
  assign bus.rx_tready_o = state == RECV ? bus.m_tready_i : 1'b1;
  // next state and result code; a device response always wins over an expiring timer
  always_comb begin
    next = state;
    res_n = res;
    case (state)
      IDLE: if (acc) begin
        next = bus.cmd_type_i == 2'b01 ? DONE : TOKEN;
        res_n = 3'd5;
      end
      TOKEN: if (bus.tok_done_i) next = is_in ? WAIT_DATA : DATA_TX;
      DATA_TX: if (bus.trn_tdone_i) next = WAIT_HSK;
      WAIT_HSK: if (bus.crc_err_i || bus.out_recv_i || bus.hsk_recv_i || tmo) begin
        next = DONE;
        res_n = bus.crc_err_i || bus.out_recv_i ? 3'd5 : bus.hsk_recv_i ? hsk_res : 3'd4;
      end
      WAIT_DATA: if (bus.crc_err_i || bus.hsk_recv_i || (bus.out_recv_i && bus.out_type_i[0]) || (!bus.out_recv_i && tmo)) begin
        next = DONE;
        res_n = bus.crc_err_i ? 3'd5 : bus.hsk_recv_i ? (bus.hsk_type_i[1] ? hsk_res : 3'd5) :
                bus.out_recv_i ? 3'd5 : 3'd4;
      end else if (bus.out_recv_i) next = RECV;
      RECV: if (bus.rx_tvalid_i && bus.m_tready_i && bus.rx_tlast_i) next = CRC_CHK;
      CRC_CHK: if (crc_any) begin
        next = DONE;
        res_n = 3'd5;
      end else if (cnt) next = SEND_ACK;
      SEND_ACK: if (bus.hsk_sent_i) begin
        next = DONE;
        res_n = mism ? 3'd6 : 3'd0;
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // state, command latch, response timer and single-cycle request strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      {typ, addr, endp, tog, mism, crc_seen, cnt, tok_send, tsend, hsend} <= '0;
      res <= '0;
      timer <= '0;
    end else begin
      state <= next;
      res <= res_n;
      if (acc) {typ, addr, endp, tog} <= {bus.cmd_type_i, bus.cmd_addr_i, bus.cmd_endp_i, bus.cmd_tog_i && bus.cmd_type_i != 2'b11};
      if (state == WAIT_DATA && bus.out_recv_i) mism <= bus.out_type_i[1] != tog;
      crc_seen <= (state == RECV || state == CRC_CHK) && crc_any;
      cnt <= state == CRC_CHK && !cnt;
      timer <= !waiting ? '0 : timer + TW'(timer != TW'(TIMEOUT));
      tok_send <= acc && bus.cmd_type_i != 2'b01;
      tsend <= state == TOKEN && bus.tok_done_i && !is_in;
      hsend <= state == CRC_CHK && cnt && !crc_any;
    end
  end
endmodule

// File: tb/tb_usb_host_xact.sv
// tb_usb_host_xact: transaction-level bench acting as scheduler, encoder, decoder and device
module tb_usb_host_xact;
  localparam int TIMEOUT = 128;
  localparam logic [2:0] HMAP [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
  typedef struct {
    logic [1:0] ctype;
    logic       tog;
    logic [6:0] addr;
    logic [3:0] endp;
    int         nb;
    int         rk;
    logic [1:0] rtype;
    logic       crc;
    int         dly;
    logic [2:0] exp_res;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];
  usb_host_xact_if bus();
  usb_host_xact #(.TIMEOUT(TIMEOUT)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(logic [1:0] ct, logic tg, logic [6:0] a, logic [3:0] e, int nb, int rk,
                              logic [1:0] rt, logic c, int d, logic [2:0] ex);
    vec_t v;
    v.ctype = ct; v.tog = tg; v.addr = a; v.endp = e; v.nb = nb; v.rk = rk;
    v.rtype = rt; v.crc = c; v.dly = d; v.exp_res = ex;
    return v;
  endfunction

  // rk: 0 handshake reply, 1 data-packet reply, 2 silent device
  function automatic logic [2:0] model_res(input vec_t v);
    if (v.ctype == 2'b01) return 3'd5;
    if (v.rk == 2) return 3'd4;
    if (v.ctype != 2'b10) return (v.rk == 1 || v.crc) ? 3'd5 : HMAP[v.rtype];
    if (v.rk == 0) return v.crc ? 3'd5 : v.rtype == 2'b10 ? 3'd1 : v.rtype == 2'b11 ? 3'd2 : 3'd5;
    if (v.rtype[0] || v.crc) return 3'd5;
    return v.rtype[1] != v.tog ? 3'd6 : 3'd0;
  endfunction

  function automatic int model_acks(input vec_t v);
    return (v.ctype == 2'b10 && v.rk == 1 && !v.rtype[0] && !v.crc) ? 1 : 0;
  endfunction

  task automatic run(input vec_t v, input logic [2:0] exp, input int exp_acks);
    logic eff, pend, take;
    logic [7:0] b;
    int n, acks, pos;
    eff = v.tog && v.ctype != 2'b11;
    bus.cmd_valid_i = 1'b1; bus.cmd_type_i = v.ctype; bus.cmd_addr_i = v.addr;
    bus.cmd_endp_i = v.endp; bus.cmd_tog_i = v.tog;
    #1 chk("cmd_ready", 32'(bus.cmd_ready_o), 1);
    tick;
    bus.cmd_valid_i = 1'b0;
    chk("tok_send", 32'(bus.tok_send_o), 32'(v.ctype != 2'b01));
    if (v.ctype != 2'b01) begin
      chk("tok_type", 32'(bus.tok_type_o), 32'(v.ctype));
      chk("tok_data", 32'(bus.tok_data_o), 32'({5'b0, v.endp, v.addr}));
      tick;
      chk("tok_send_once", 32'(bus.tok_send_o), 0);
      bus.tok_done_i = 1'b1; tick; bus.tok_done_i = 1'b0;
      if (v.ctype != 2'b10) begin
        chk("trn_tsend", 32'(bus.trn_tsend_o), 1);
        chk("trn_ttype", 32'(bus.trn_ttype_o), 32'({eff, 1'b0}));
        n = 0;
        for (int i = 0; i < v.nb; i++) begin
          b = 8'($urandom);
          bus.s_tvalid_i = 1'b1; bus.s_tdata_i = b; bus.s_tlast_i = i == v.nb - 1;
          do begin
            take = $urandom_range(0, 3) != 0;
            bus.trn_tready_i = take;
            #1;
            chk("trn_tvalid", 32'(bus.trn_tvalid_o), 1);
            chk("trn_tdata", 32'(bus.trn_tdata_o), 32'(b));
            chk("trn_tlast", 32'(bus.trn_tlast_o), 32'(i == v.nb - 1));
            chk("s_tready", 32'(bus.s_tready_o), 32'(take));
            n += int'(take);
            tick;
          end while (!take);
        end
        bus.s_tvalid_i = 1'b0; bus.s_tlast_i = 1'b0; bus.trn_tready_i = 1'b0;
        #1 chk("trn_tvalid_idle", 32'(bus.trn_tvalid_o), 0);
        chk("fwd_bytes", n, v.nb);
        tick;
        chk("trn_tsend_once", 32'(bus.trn_tsend_o), 0);
        bus.trn_tdone_i = 1'b1; tick; bus.trn_tdone_i = 1'b0;
      end
      repeat (v.dly) tick;
      if (v.rk == 0) begin
        bus.hsk_recv_i = 1'b1; bus.hsk_type_i = v.rtype; bus.crc_err_i = v.crc;
        tick;
        bus.hsk_recv_i = 1'b0; bus.crc_err_i = 1'b0;
      end else if (v.rk == 1) begin
        bus.out_recv_i = 1'b1; bus.out_type_i = v.rtype;
        tick;
        bus.out_recv_i = 1'b0;
        if (v.ctype == 2'b10 && !v.rtype[0]) begin
          for (int i = 0; i < v.nb; i++) begin
            b = 8'($urandom);
            bus.rx_tvalid_i = 1'b1; bus.rx_tdata_i = b; bus.rx_tlast_i = i == v.nb - 1;
            do begin
              take = $urandom_range(0, 3) != 0;
              bus.m_tready_i = take;
              #1;
              chk("m_tvalid", 32'(bus.m_tvalid_o), 1);
              chk("m_tdata", 32'(bus.m_tdata_o), 32'(b));
              chk("m_tlast", 32'(bus.m_tlast_o), 32'(i == v.nb - 1));
              chk("rx_tready", 32'(bus.rx_tready_o), 32'(take));
              tick;
            end while (!take);
          end
          bus.rx_tvalid_i = 1'b0; bus.rx_tlast_i = 1'b0; bus.m_tready_i = 1'b0;
        end
      end
    end
    pos = int'($urandom_range(0, 1));
    n = 0; acks = 0; pend = 1'b0;
    while (!bus.done_o && n < 400) begin
      bus.crc_err_i = v.crc && v.rk == 1 && v.ctype == 2'b10 && n == pos;
      bus.hsk_sent_i = pend;
      pend = 1'b0;
      if (bus.hsk_send_o) begin
        acks++;
        chk("hsk_type", 32'(bus.hsk_type_o), 0);
        pend = 1'b1;
      end
      tick;
      n++;
    end
    bus.crc_err_i = 1'b0; bus.hsk_sent_i = 1'b0;
    if (v.rk == 2 && v.ctype != 2'b01) chk("timeout_cycles", n, TIMEOUT);
    else if (!(v.ctype == 2'b10 && v.rk == 1 && !v.rtype[0])) chk("resp_latency", n, 0);
    chk("done", 32'(bus.done_o), 1);
    chk("result", 32'(bus.result_o), 32'(exp));
    chk("acks", acks, exp_acks);
    tick;
    chk("done_once", 32'(bus.done_o), 0);
    chk("idle_ready", 32'(bus.cmd_ready_o), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {bus.cmd_valid_i, bus.cmd_tog_i, bus.tok_done_i, bus.trn_busy_i, bus.trn_tdone_i, bus.hsk_sent_i,
     bus.hsk_recv_i, bus.out_recv_i, bus.crc_err_i, bus.s_tvalid_i, bus.s_tlast_i, bus.trn_tready_i,
     bus.rx_tvalid_i, bus.rx_tlast_i, bus.m_tready_i} = '0;
    bus.cmd_type_i = 2'b00; bus.cmd_addr_i = 7'd0; bus.cmd_endp_i = 4'd0;
    bus.hsk_type_i = 2'b00; bus.out_type_i = 2'b00;
    bus.s_tdata_i = 8'h00; bus.rx_tdata_i = 8'h00;
    repeat (2) tick;
    reset = 1'b0;
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 1);
    chk("rst_rx_tready", 32'(bus.rx_tready_o), 1);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_result", 32'(bus.result_o), 0);
    chk("rst_tok_send", 32'(bus.tok_send_o), 0);
    chk("rst_tok_data", 32'(bus.tok_data_o), 0);
    chk("rst_trn_tsend", 32'(bus.trn_tsend_o), 0);
    chk("rst_hsk_send", 32'(bus.hsk_send_o), 0);
    chk("rst_s_tready", 32'(bus.s_tready_o), 0);
    chk("rst_m_tvalid", 32'(bus.m_tvalid_o), 0);
    tbl.push_back(mk(2'b00, 1'b1, 7'd5, 4'd2, 3, 0, 2'b00, 1'b0, 1, 3'd0));
    tbl.push_back(mk(2'b11, 1'b1, 7'd9, 4'd0, 2, 0, 2'b10, 1'b0, 0, 3'd1));
    tbl.push_back(mk(2'b10, 1'b1, 7'd3, 4'd1, 4, 1, 2'b10, 1'b0, 2, 3'd0));
    tbl.push_back(mk(2'b10, 1'b1, 7'd3, 4'd1, 4, 1, 2'b00, 1'b0, 0, 3'd6));
    tbl.push_back(mk(2'b10, 1'b0, 7'd7, 4'd3, 1, 2, 2'b00, 1'b0, 0, 3'd4));
    tbl.push_back(mk(2'b10, 1'b0, 7'd7, 4'd3, 2, 1, 2'b00, 1'b1, 1, 3'd5));
    tbl.push_back(mk(2'b10, 1'b0, 7'd1, 4'd1, 1, 0, 2'b11, 1'b0, 0, 3'd2));
    tbl.push_back(mk(2'b00, 1'b0, 7'd2, 4'd4, 2, 0, 2'b01, 1'b0, 3, 3'd3));
    tbl.push_back(mk(2'b01, 1'b0, 7'd0, 4'd0, 0, 0, 2'b00, 1'b0, 0, 3'd5));
    tbl.push_back(mk(2'b00, 1'b1, 7'd127, 4'd15, 0, 2, 2'b00, 1'b0, 0, 3'd4));
    tbl.push_back(mk(2'b00, 1'b0, 7'd4, 4'd4, 1, 0, 2'b00, 1'b1, 0, 3'd5));
    tbl.push_back(mk(2'b10, 1'b1, 7'd6, 4'd2, 2, 1, 2'b11, 1'b0, 0, 3'd5));
    tbl.push_back(mk(2'b10, 1'b0, 7'd6, 4'd2, 1, 0, 2'b00, 1'b0, 0, 3'd5));
    tbl.push_back(mk(2'b00, 1'b1, 7'd8, 4'd8, 1, 1, 2'b10, 1'b0, 0, 3'd5));
    tbl.push_back(mk(2'b10, 1'b0, 7'd5, 4'd5, 1, 0, 2'b10, 1'b0, 127, 3'd1));
    tbl.push_back(mk(2'b00, 1'b0, 7'd5, 4'd5, 2, 0, 2'b10, 1'b0, 127, 3'd1));
    foreach (tbl[i]) run(tbl[i], tbl[i].exp_res, model_acks(tbl[i]));
    for (int t = 0; t < 40; t++) begin
      vec_t v;
      int r;
      r = int'($urandom_range(0, 9));
      v.ctype = r == 0 ? 2'b01 : r < 4 ? 2'b00 : r < 6 ? 2'b11 : 2'b10;
      v.tog = 1'($urandom);
      v.addr = 7'($urandom);
      v.endp = 4'($urandom);
      v.rk = v.ctype == 2'b01 ? 0 : $urandom_range(0, 9) == 0 ? 2 : int'($urandom_range(0, 1));
      v.nb = (v.ctype == 2'b10 ? 1 : 0) + int'($urandom_range(0, 3));
      v.rtype = 2'($urandom);
      v.crc = $urandom_range(0, 3) == 0;
      v.dly = v.rk == 2 ? 0 : int'($urandom_range(0, 3));
      v.exp_res = model_res(v);
      run(v, v.exp_res, model_acks(v));
    end
    bus.cmd_valid_i = 1'b1; bus.cmd_type_i = 2'b10; bus.cmd_tog_i = 1'b1;
    tick;
    bus.cmd_valid_i = 1'b0;
    tick;
    bus.tok_done_i = 1'b1; tick; bus.tok_done_i = 1'b0;
    bus.out_recv_i = 1'b1; bus.out_type_i = 2'b10; tick; bus.out_recv_i = 1'b0;
    bus.rx_tvalid_i = 1'b1; bus.rx_tdata_i = 8'hA5; bus.m_tready_i = 1'b0;
    #1;
    chk("recv_m_tvalid", 32'(bus.m_tvalid_o), 1);
    chk("recv_rx_tready", 32'(bus.rx_tready_o), 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_ready", 32'(bus.cmd_ready_o), 1);
    chk("mid_rst_done", 32'(bus.done_o), 0);
    chk("mid_rst_rx_tready", 32'(bus.rx_tready_o), 1);
    chk("mid_rst_m_tvalid", 32'(bus.m_tvalid_o), 0);
    bus.rx_tvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_no_done", 32'(bus.done_o), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
